// File: rtl/mc_control_seq.sv
// Multi-cycle main control FSM for the MIPS-subset datapath: fetch/decode/execute/
// memory/write-back with memory wait states, mult/div handshake and vectored exceptions.
module mc_control_seq #(
  parameter int MEM_WAIT   = 3,
  parameter int MD_TIMEOUT = 64,
  parameter int CW         = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  input  logic       md_done,
  input  logic       div0,
  output logic       pc_write,
  output logic [2:0] pc_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic [1:0] iord,
  output logic       exc_sel,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [2:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       alu_out_write,
  output logic       ab_write,
  output logic       mdr_write,
  output logic       epc_write,
  output logic       md_start,
  output logic       md_sel,
  output logic       hilo_write,
  output logic       reset_out
);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
    S_MEM_ADDR, S_MEM_WR, S_MEM_RD, S_MEM_WB, S_BRANCH, S_JUMP,
    S_MD_START, S_MD_WAIT, S_MD_WB, S_EXC
  } state_t;

  typedef enum logic [1:0] {EX_OPC, EX_OVF, EX_DIV0} exc_t;

  localparam logic [CW-1:0] MEM_LAST = CW'(MEM_WAIT);
  localparam logic [CW-1:0] EXC_LAST = CW'(MEM_WAIT + 1);
  localparam logic [CW-1:0] MD_LAST  = CW'(MD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state, nxt;
  exc_t          exc_code, nxt_exc;
  logic [CW-1:0] cnt;

  // IR is held after fetch, so opcode/funct are stable for the whole instruction.
  logic is_r, r_alu, r_md, r_mf, r_jr, ovf_chk, is_div;
  assign is_r    = (opcode == 6'h00);
  assign r_alu   = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 || funct == 6'h2A);
  assign r_md    = is_r && (funct == 6'h18 || funct == 6'h1A);
  assign r_mf    = is_r && (funct == 6'h10 || funct == 6'h12);
  assign r_jr    = is_r && (funct == 6'h08);
  assign is_div  = (funct == 6'h1A);
  assign ovf_chk = (is_r && (funct == 6'h20 || funct == 6'h22)) || (opcode == 6'h08);

  always_comb begin
    nxt     = state;
    nxt_exc = exc_code;
    unique case (state)
      S_RESET:  nxt = S_FETCH;
      S_FETCH:  if (cnt == MEM_LAST) nxt = S_DECODE;
      S_DECODE: begin
        if (is_r) begin
          if (r_alu)     nxt = S_EXEC_R;
          else if (r_md) nxt = S_MD_START;
          else if (r_mf) nxt = S_WB_R;
          else if (r_jr) nxt = S_JUMP;
          else begin nxt = S_EXC; nxt_exc = EX_OPC; end
        end else begin
          case (opcode)
            6'h08, 6'h09: nxt = S_EXEC_I;
            6'h23, 6'h2B: nxt = S_MEM_ADDR;
            6'h04, 6'h05: nxt = S_BRANCH;
            6'h0F:        nxt = S_WB_I;
            6'h02, 6'h03: nxt = S_JUMP;
            default: begin nxt = S_EXC; nxt_exc = EX_OPC; end
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        if (overflow && ovf_chk) begin nxt = S_EXC; nxt_exc = EX_OVF; end
        else nxt = (state == S_EXEC_R) ? S_WB_R : S_WB_I;
      end
      S_MEM_ADDR: nxt = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (cnt == MEM_LAST) nxt = S_MEM_WB;
      S_MD_START: nxt = S_MD_WAIT;
      S_MD_WAIT: begin
        // A zero divisor outranks a simultaneous done pulse.
        if (div0 && is_div) begin nxt = S_EXC; nxt_exc = EX_DIV0; end
        else if (md_done)        nxt = S_MD_WB;
        else if (cnt == MD_LAST) nxt = S_FETCH;
      end
      S_EXC: if (cnt == EXC_LAST) nxt = S_FETCH;
      S_WB_R, S_WB_I, S_MEM_WR, S_MEM_WB, S_BRANCH, S_JUMP, S_MD_WB: nxt = S_FETCH;
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RESET;
      exc_code <= EX_OPC;
      cnt      <= '0;
    end else begin
      state    <= nxt;
      exc_code <= nxt_exc;
      if (nxt != state)      cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  // Moore decode of the registered state; only the branch decision looks at zero.
  always_comb begin
    pc_write = 1'b0; pc_src = 3'b000; ir_write = 1'b0; mem_write = 1'b0;
    iord = 2'b00; exc_sel = 1'b0; reg_write = 1'b0; reg_dst = 2'b00;
    mem_to_reg = 3'b000; alu_src_a = 2'b00; alu_src_b = 2'b00; alu_op = 3'b000;
    alu_out_write = 1'b0; ab_write = 1'b0; mdr_write = 1'b0; epc_write = 1'b0;
    md_start = 1'b0; md_sel = 1'b0; hilo_write = 1'b0; reset_out = 1'b0;
    unique case (state)
      S_RESET: reset_out = 1'b1;
      S_FETCH: begin
        alu_src_b = 2'b01; alu_op = 3'b001;
        if (cnt == MEM_LAST) begin ir_write = 1'b1; pc_write = 1'b1; end
      end
      S_DECODE: begin
        ab_write = 1'b1; alu_src_b = 2'b11; alu_op = 3'b001; alu_out_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01; alu_out_write = 1'b1;
        case (funct)
          6'h22:   alu_op = 3'b010;
          6'h24:   alu_op = 3'b011;
          6'h2A:   alu_op = 3'b111;
          default: alu_op = 3'b001;
        endcase
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 2'b01; alu_src_b = 2'b10; alu_op = 3'b001; alu_out_write = 1'b1;
      end
      S_WB_R: begin
        reg_write = 1'b1; reg_dst = 2'b01;
        if (funct == 6'h10)      mem_to_reg = 3'b010;
        else if (funct == 6'h12) mem_to_reg = 3'b011;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        if (opcode == 6'h0F) mem_to_reg = 3'b100;
      end
      S_MEM_WR: begin mem_write = 1'b1; iord = 2'b01; end
      S_MEM_RD: begin
        iord = 2'b01;
        if (cnt == MEM_LAST) mdr_write = 1'b1;
      end
      S_MEM_WB: begin reg_write = 1'b1; mem_to_reg = 3'b001; end
      S_BRANCH: begin
        alu_src_a = 2'b01; alu_op = 3'b010; pc_src = 3'b001;
        pc_write  = (opcode == 6'h05) ? !zero : zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = is_r ? 3'b011 : 3'b010;
        if (opcode == 6'h03) begin reg_write = 1'b1; reg_dst = 2'b10; mem_to_reg = 3'b101; end
      end
      S_MD_START: begin md_start = 1'b1; md_sel = is_div; end
      S_MD_WAIT:  md_sel = is_div;
      S_MD_WB:    begin hilo_write = 1'b1; md_sel = is_div; end
      S_EXC: begin
        iord    = (exc_code == EX_OVF) ? 2'b10 : 2'b11;
        exc_sel = (exc_code == EX_OPC);
        if (cnt == '0) begin
          epc_write = 1'b1; alu_src_b = 2'b01; alu_op = 3'b010;
        end
        if (cnt == EXC_LAST) begin pc_write = 1'b1; pc_src = 3'b100; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_seq.sv
// Directed bench for mc_control_seq (MEM_WAIT=3, MD_TIMEOUT=64): hand-computed
// per-cycle output expectations, sampled on the falling edge.
module tb_mc_control_seq;
  logic clk = 1'b0;
  logic reset, overflow, zero, md_done, div0;
  logic [5:0] opcode, funct;
  logic pc_write, ir_write, mem_write, exc_sel, reg_write, alu_out_write, ab_write;
  logic mdr_write, epc_write, md_start, md_sel, hilo_write, reset_out;
  logic [2:0] pc_src, mem_to_reg, alu_op;
  logic [1:0] iord, reg_dst, alu_src_a, alu_src_b;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  mc_control_seq #(.MEM_WAIT(3), .MD_TIMEOUT(64), .CW(7)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .overflow(overflow),
    .zero(zero), .md_done(md_done), .div0(div0), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_write(mem_write), .iord(iord), .exc_sel(exc_sel),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_out_write(alu_out_write), .ab_write(ab_write), .mdr_write(mdr_write),
    .epc_write(epc_write), .md_start(md_start), .md_sel(md_sel),
    .hilo_write(hilo_write), .reset_out(reset_out)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // From a FETCH first-cycle sample point, load the instruction and land in DECODE.
  task automatic to_decode(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn;
    cyc(4);
  endtask

  initial begin
    reset = 1'b1; overflow = 1'b0; zero = 1'b0; md_done = 1'b0; div0 = 1'b0;
    opcode = 6'h00; funct = 6'h20;
    cyc(2);
    chk("rst_reset_out", int'(reset_out), 1);
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_alu_src_b", int'(alu_src_b), 0);
    reset = 1'b0; #1;
    chk("rel_reset_out", int'(reset_out), 1);

    // Fetch of ADD: ir_write only on the 4th fetch cycle
    cyc(1);
    chk("f0_reset_out", int'(reset_out), 0);
    chk("f0_ir_write", int'(ir_write), 0);
    chk("f0_alu_op", int'(alu_op), 1);
    cyc(2);
    chk("f2_ir_write", int'(ir_write), 0);
    cyc(1);
    chk("f3_ir_write", int'(ir_write), 1);
    chk("f3_pc_write", int'(pc_write), 1);
    cyc(1);
    chk("dec_ab_write", int'(ab_write), 1);
    chk("dec_alu_src_b", int'(alu_src_b), 3);
    cyc(1);
    chk("exr_alu_op", int'(alu_op), 1);
    chk("exr_alu_src_a", int'(alu_src_a), 1);
    cyc(1);
    chk("wbr_reg_write", int'(reg_write), 1);
    chk("wbr_reg_dst", int'(reg_dst), 1);
    chk("wbr_mem_to_reg", int'(mem_to_reg), 0);
    cyc(1);
    chk("wbr_next_fetch", int'(alu_src_b), 1);

    // ADD with overflow -> OVF exception
    to_decode(6'h00, 6'h20);
    cyc(1); overflow = 1'b1;
    cyc(1); overflow = 1'b0;
    chk("ovf_epc_write", int'(epc_write), 1);
    chk("ovf_iord", int'(iord), 2);
    chk("ovf_alu_op", int'(alu_op), 2);
    chk("ovf_reg_write", int'(reg_write), 0);
    cyc(1);
    chk("ovf_epc_once", int'(epc_write), 0);
    cyc(2);
    chk("ovf_c3_pc_write", int'(pc_write), 0);
    cyc(1);
    chk("ovf_c4_pc_write", int'(pc_write), 1);
    chk("ovf_c4_pc_src", int'(pc_src), 4);
    cyc(1);

    // Bad opcode 3F
    to_decode(6'h3F, 6'h00);
    cyc(1);
    chk("opc_iord", int'(iord), 3);
    chk("opc_exc_sel", int'(exc_sel), 1);
    chk("opc_epc_write", int'(epc_write), 1);
    cyc(4);
    chk("opc_pc_write", int'(pc_write), 1);
    chk("opc_pc_src", int'(pc_src), 4);
    cyc(1);

    // BEQ taken, BNE with zero=1 not taken, zero=0 taken
    to_decode(6'h04, 6'h00);
    cyc(1); zero = 1'b1; #1;
    chk("beq_pc_write", int'(pc_write), 1);
    chk("beq_pc_src", int'(pc_src), 1);
    chk("beq_alu_op", int'(alu_op), 2);
    cyc(1);
    to_decode(6'h05, 6'h00);
    cyc(1); #1;
    chk("bne_z1_pc_write", int'(pc_write), 0);
    zero = 1'b0; #1;
    chk("bne_z0_pc_write", int'(pc_write), 1);
    cyc(1);

    // DIV with div0 and md_done together on wait cycle 5
    to_decode(6'h00, 6'h1A);
    cyc(1);
    chk("div_md_start", int'(md_start), 1);
    chk("div_md_sel", int'(md_sel), 1);
    cyc(1);
    chk("div_start_once", int'(md_start), 0);
    cyc(4); div0 = 1'b1; md_done = 1'b1;
    chk("div_w5_hilo", int'(hilo_write), 0);
    cyc(1); div0 = 1'b0; md_done = 1'b0;
    chk("div0_iord", int'(iord), 3);
    chk("div0_exc_sel", int'(exc_sel), 0);
    chk("div0_epc_write", int'(epc_write), 1);
    chk("div0_hilo", int'(hilo_write), 0);
    cyc(4);
    chk("div0_pc_write", int'(pc_write), 1);
    cyc(1);

    // MULT: div0 is ignored, md_done gives one hilo_write cycle
    to_decode(6'h00, 6'h18);
    cyc(1);
    chk("mult_md_sel", int'(md_sel), 0);
    cyc(3); md_done = 1'b1; div0 = 1'b1;
    cyc(1); md_done = 1'b0; div0 = 1'b0;
    chk("mult_hilo", int'(hilo_write), 1);
    chk("mult_epc", int'(epc_write), 0);
    cyc(1);
    chk("mult_hilo_once", int'(hilo_write), 0);

    // MULT timeout after 64 wait cycles, no HI/LO write
    to_decode(6'h00, 6'h18);
    cyc(2);
    cyc(63);
    chk("to_last_hilo", int'(hilo_write), 0);
    chk("to_last_still_wait", int'(alu_src_b), 0);
    cyc(1);
    chk("to_fetch_b", int'(alu_src_b), 1);
    chk("to_fetch_hilo", int'(hilo_write), 0);
    cyc(3);
    chk("to_fetch_ir_write", int'(ir_write), 1);
    cyc(1);

    // Hmm: that last cyc(1) lands in DECODE of the still-loaded MULT; reset cleanly
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);

    // LW interrupted by reset during the memory wait
    to_decode(6'h23, 6'h00);
    cyc(1);
    chk("lw_addr_src_b", int'(alu_src_b), 2);
    cyc(1);
    chk("lw_rd_iord", int'(iord), 1);
    chk("lw_rd0_mdr", int'(mdr_write), 0);
    cyc(1); reset = 1'b1;
    cyc(1);
    chk("lwrst_reset_out", int'(reset_out), 1);
    chk("lwrst_iord", int'(iord), 0);
    chk("lwrst_mem_write", int'(mem_write), 0);
    chk("lwrst_mdr_write", int'(mdr_write), 0);
    reset = 1'b0;
    cyc(1);

    // Full LW
    to_decode(6'h23, 6'h00);
    cyc(5);
    chk("lw_rd3_mdr", int'(mdr_write), 1);
    cyc(1);
    chk("lw_wb_reg_write", int'(reg_write), 1);
    chk("lw_wb_mem_to_reg", int'(mem_to_reg), 1);
    chk("lw_wb_reg_dst", int'(reg_dst), 0);
    cyc(1);

    // SW
    to_decode(6'h2B, 6'h00);
    cyc(2);
    chk("sw_mem_write", int'(mem_write), 1);
    chk("sw_iord", int'(iord), 1);
    cyc(1);
    chk("sw_once", int'(mem_write), 0);

    // JAL
    to_decode(6'h03, 6'h00);
    cyc(1);
    chk("jal_pc_src", int'(pc_src), 2);
    chk("jal_reg_dst", int'(reg_dst), 2);
    chk("jal_mem_to_reg", int'(mem_to_reg), 5);
    chk("jal_reg_write", int'(reg_write), 1);
    cyc(1);

    // JR
    to_decode(6'h00, 6'h08);
    cyc(1);
    chk("jr_pc_src", int'(pc_src), 3);
    chk("jr_reg_write", int'(reg_write), 0);
    cyc(1);

    // LUI
    to_decode(6'h0F, 6'h00);
    cyc(1);
    chk("lui_mem_to_reg", int'(mem_to_reg), 4);
    chk("lui_reg_dst", int'(reg_dst), 0);
    cyc(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
